// File: rtl/deinterleaver_pkg.sv
// Shared constants and state encoding for the
// round-robin lane deinterleaver.
package deinterleaver_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N_OUTPUTS  = 4;
  localparam int LANE_W         = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/deinterleaver_lane_counter.sv
// Modulo-4 lane pointer; load0 restarts a frame
// with lane 0 already consumed.
module lane_counter
  import deinterleaver_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load0,
  input  logic              inc,
  output logic [LANE_W-1:0] lane
);

  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] lane_d;

  always_comb begin
    lane_d = lane_q;
    unique case (1'b1)
      load0:   lane_d = LANE_W'(1);
      inc:     lane_d = lane_q + LANE_W'(1);
      default: lane_d = lane_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign lane = lane_q;

endmodule

// File: rtl/deinterleaver.sv
// Rebuilds 4-lane frames from a round-robin word
// stream, aligning on sync and flagging misalignment.
module deinterleaver
  import deinterleaver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_OUTPUTS  = DEF_N_OUTPUTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  en,
  input  logic                  sync,
  output logic [DATA_WIDTH-1:0] r0,
  output logic [DATA_WIDTH-1:0] r1,
  output logic [DATA_WIDTH-1:0] r2,
  output logic [DATA_WIDTH-1:0] r3,
  output logic                  valid,
  output logic [LANE_W-1:0]     lane,
  output logic                  err
);

  localparam int N_STAGE = N_OUTPUTS - 1;
  localparam logic [LANE_W-1:0] LAST =
    LANE_W'(N_OUTPUTS - 1);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] stage_q [N_STAGE];
  logic [DATA_WIDTH-1:0] r0_q, r1_q, r2_q, r3_q;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  load0;
  logic                  inc;
  logic                  wr_en;
  logic [LANE_W-1:0]     wr_idx;

  lane_counter u_lane (
    .clk   (clk),
    .rst   (rst),
    .load0 (load0),
    .inc   (inc),
    .lane  (lane)
  );

  always_comb begin
    state_d = state_q;
    load0   = 1'b0;
    inc     = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = lane;
    valid_d = 1'b0;
    err_d   = err_q;
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            state_d = LOCKED;
            load0   = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = '0;
          end
        end
        LOCKED: begin
          // sync away from lane 0 drops the partial frame
          if (sync && lane != '0) begin
            load0  = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
            err_d  = 1'b1;
          end else begin
            inc = 1'b1;
            if (lane == LAST) begin
              valid_d = 1'b1;
            end else begin
              wr_en = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      for (int i = 0; i < N_STAGE; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < N_STAGE; i++) begin
        if (wr_en && wr_idx == LANE_W'(i)) begin
          stage_q[i] <= data_in;
        end
      end
      if (valid_d) begin
        r0_q <= stage_q[0];
        r1_q <= stage_q[1];
        r2_q <= stage_q[2];
        r3_q <= data_in;
      end
    end
  end

  assign r0    = r0_q;
  assign r1    = r1_q;
  assign r2    = r2_q;
  assign r3    = r3_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_deinterleaver.sv
// Scoreboard bench: stimulus pushes expected frames,
// a negedge monitor pops and compares on each valid.
module tb_deinterleaver;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic        e;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic [15:0] r0, r1, r2, r3;
  logic        valid;
  logic [1:0]  lane;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_vcyc = -1;
  int prev_vcyc = -1;
  logic prev_valid = 1'b0;
  frame_t exp_q[$];

  deinterleaver #(
    .DATA_WIDTH (16),
    .N_OUTPUTS  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .en      (en),
    .sync    (sync),
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3),
    .valid   (valid),
    .lane    (lane),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && valid) begin
      frame_t f;
      check("valid_width", 32'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        f = exp_q.pop_front();
        check("r0", 32'(r0), 32'(f.a));
        check("r1", 32'(r1), 32'(f.b));
        check("r2", 32'(r2), 32'(f.c));
        check("r3", 32'(r3), 32'(f.d));
        check("err_at_valid", 32'(err), 32'(f.e));
      end
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
    prev_valid = valid;
  end

  task automatic send(
    input logic [15:0] d,
    input logic        s
  );
    data_in = d;
    sync    = s;
    en      = 1'b1;
    @(posedge clk);
    #1;
    en   = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data_in = 16'hDEAD;
      sync    = 1'b1;
      @(posedge clk);
      #1;
    end
    sync = 1'b0;
  endtask

  task automatic push(
    input logic [15:0] a, b, c, d,
    input logic        e
  );
    frame_t f;
    f = '{a: a, b: b, c: c, d: d, e: e};
    exp_q.push_back(f);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #23;
    check("rst_lane", 32'(lane), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_r", {r0, r1}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    send(16'hAAAA, 0);
    send(16'hBBBB, 0);
    check("hunt_lane", 32'(lane), 0);
    check("hunt_err", 32'(err), 0);

    push(1, 2, 3, 4, 0);
    send(1, 1);
    check("lock_lane", 32'(lane), 1);
    send(2, 0);
    send(3, 0);
    send(4, 0);
    check("lat_valid", 32'(valid), 1);
    check("lat_r3", 32'(r3), 4);
    idle(1);
    check("pulse_end", 32'(valid), 0);
    drain();

    push(1, 2, 3, 4, 0);
    push(7, 8, 9, 10, 1);
    send(1, 1);
    send(2, 0);
    send(3, 0);
    send(4, 0);
    send(5, 1);
    send(6, 0);
    send(7, 1);
    check("resync_err", 32'(err), 1);
    check("resync_lane", 32'(lane), 1);
    send(8, 0);
    send(9, 0);
    send(10, 0);
    drain();
    idle(2);
    check("hold_r0", 32'(r0), 7);

    push(16'h10, 16'h11, 16'h12, 16'h13, 1);
    send(16'h10, 1);
    idle(3);
    send(16'h11, 0);
    idle(3);
    send(16'h12, 0);
    idle(3);
    send(16'h13, 0);
    idle(3);
    drain();

    send(16'h30, 1);
    send(16'h31, 0);
    rst = 1'b0;
    #12;
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_lane", 32'(lane), 0);
    check("mid_rst_r3", 32'(r3), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(16'h20, 16'h21, 16'h22, 16'h23, 0);
    send(16'h20, 1);
    send(16'h21, 0);
    send(16'h22, 0);
    send(16'h23, 0);
    drain();

    push(1, 2, 3, 4, 0);
    push(5, 6, 7, 8, 0);
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), (i == 1 || i == 5));
    end
    drain();
    check("b2b_gap", last_vcyc - prev_vcyc, 4);
    check("final_err", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
